rv32_muldiv: RTL and testbench

- Parametrised, iterative multiply/divide unit implementing the RV32M operations. It sits beside the single-cycle ALU in the execute stage.
- Accepts one operation via a valid/ready handshake and computes it one bit per cycle using shift-add multiply and restoring divide.
- Returns a registered result held until the consumer accepts it.
- Pipeline flush support discards in-flight work.

---
 rtl/rv32_muldiv.sv | 177 +++++++++++++++++
 tb/tb_rv32_muldiv.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, registered result held until the consumer accepts it.
module rv32_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      op_in,
  input  logic [XLEN-1:0] src1_in,
  input  logic [XLEN-1:0] src2_in,
  input  logic            flush_in,
  output logic            result_valid_out,
  input  logic            result_ready_in,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter;
  logic [2:0]      op_q;
  logic            neg1, neg2;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] hi_q, lo_q;

  // Operand decode at accept
  logic            sgn1, sgn2, s1neg, s2neg;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0] fast_res;

  assign ready_out = (state == IDLE);
  assign accept    = valid_in && ready_out && !flush_in;

  assign sgn1  = !(op_in == OP_MULHU || op_in == OP_DIVU || op_in == OP_REMU);
  assign sgn2  = (op_in == OP_MUL || op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign s1neg = sgn1 && src1_in[XLEN-1];
  assign s2neg = sgn2 && src2_in[XLEN-1];
  assign abs1  = s1neg ? -src1_in : src1_in;
  assign abs2  = s2neg ? -src2_in : src2_in;

  assign div_zero = op_in[2] && (src2_in == '0);
  assign div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                    (src1_in == MOST_NEG) && (src2_in == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = op_in[1] ? src1_in : '1;
    else if (div_ovf) fast_res = op_in[1] ? '0 : MOST_NEG;
  end

  // One iteration step. Multiply shifts {hi,lo} right with the multiplier in lo;
  // divide shifts {rem,quotient} left with the dividend draining out of lo.
  logic [XLEN:0]   sum, rs, diff;
  logic [XLEN-1:0] hi_step, lo_step;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    rs      = {hi_q, lo_q[XLEN-1]};
    diff    = rs - {1'b0, b_q};
    hi_step = hi_q;
    lo_step = lo_q;
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        hi_step = diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = rs[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[XLEN:1];
      lo_step = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fixup of the unsigned magnitudes
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = (neg1 ^ neg2) ? -prod : prod;
    quo_s   = (neg1 ^ neg2) ? -lo_q : lo_q;
    rem_s   = neg1 ? -hi_q : hi_q;
    fix_res = '0;
    case (op_q)
      OP_MUL:                      fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = quo_s;
      OP_REM, OP_REMU:             fix_res = rem_s;
      default:                     fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : BUSY;
      BUSY:    if (counter == CW'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (result_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_in) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter          <= '0;
      op_q             <= '0;
      neg1             <= 1'b0;
      neg2             <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
    end else if (flush_in) begin
      counter          <= '0;
      result_valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op_in;
          neg1 <= s1neg;
          neg2 <= s2neg;
          a_q  <= abs1;
          b_q  <= abs2;
          hi_q <= '0;
          lo_q <= op_in[2] ? abs1 : abs2;
          if (fast) begin
            counter          <= '0;
            result_out       <= fast_res;
            result_valid_out <= 1'b1;
          end else begin
            counter <= CW'(XLEN);
          end
        end
        BUSY: begin
          hi_q    <= hi_step;
          lo_q    <= lo_step;
          counter <= counter - CW'(1);
        end
        FIXUP: begin
          result_out       <= fix_res;
          result_valid_out <= 1'b1;
        end
        DONE: if (result_ready_in) result_valid_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_muldiv.sv
// Scoreboard bench for rv32_muldiv at XLEN=32 and XLEN=64.
module tb_rv32_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        valid_in, ready_out, flush_in, rv, rr;
  logic [2:0]  op_in;
  logic [31:0] src1_in, src2_in, res;

  logic        v64, rdy64, fl64, rv64, rr64;
  logic [2:0]  op64;
  logic [63:0] s1_64, s2_64, res64;

  rv32_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_out(ready_out),
    .op_in(op_in), .src1_in(src1_in), .src2_in(src2_in), .flush_in(flush_in),
    .result_valid_out(rv), .result_ready_in(rr), .result_out(res)
  );

  rv32_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .valid_in(v64), .ready_out(rdy64),
    .op_in(op64), .src1_in(s1_64), .src2_in(s2_64), .flush_in(fl64),
    .result_valid_out(rv64), .result_ready_in(rr64), .result_out(res64)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    op_in = op; src1_in = a; src2_in = b; valid_in = 1'b1;
    sbq.push_back({32'b0, exp});
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    op_in = 3'($urandom); src1_in = $urandom; src2_in = $urandom;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (!rv && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume32;
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    @(negedge clk);
    op64 = op; s1_64 = a; s2_64 = b; v64 = 1'b1;
    sbq.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    v64 = 1'b0;
    op64 = 3'($urandom); s1_64 = {$urandom, $urandom}; s2_64 = {$urandom, $urandom};
  endtask

  task automatic wait64(output int lat);
    lat = 1;
    while (!rv64 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume64;
    rr64 = 1'b1;
    @(negedge clk);
    rr64 = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rv !== 1'b0 || res !== 32'd0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset32: valid=%b result=%h ready=%b, want 0/00000000/1", rv, res, ready_out);
    end
    checks++;
    if (rv64 !== 1'b0 || res64 !== 64'd0 || rdy64 !== 1'b1) begin
      errors++;
      $display("FAIL reset64: valid=%b result=%h ready=%b, want 0/0/1", rv64, res64, rdy64);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_normal32;
    logic [2:0]  ops[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as[8]  = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs[8]  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex[8]  = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int lat;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      issue32(ops[i], as[i], bs[i], ex[i]);
      wait32(lat);
      e = sbq.pop_front();
      checks++;
      if (lat != 34) begin
        errors++;
        $display("FAIL normal32[%0d] latency: got %0d want 34", i, lat);
      end
      checks++;
      if (res !== e[31:0]) begin
        errors++;
        $display("FAIL normal32[%0d] result op=%0d: got %h want %h", i, ops[i], res, e[31:0]);
      end
      consume32;
      checks++;
      if (rv !== 1'b0 || ready_out !== 1'b1) begin
        errors++;
        $display("FAIL normal32[%0d] handshake: valid=%b ready=%b want 0/1", i, rv, ready_out);
      end
    end
  endtask

  task automatic test_fast_path;
    logic [2:0]  ops[4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex[4]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int lat;
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue32(ops[i], as[i], bs[i], ex[i]);
      wait32(lat);
      e = sbq.pop_front();
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL fast[%0d] latency: got %0d want 1", i, lat);
      end
      checks++;
      if (res !== e[31:0]) begin
        errors++;
        $display("FAIL fast[%0d] result: got %h want %h", i, res, e[31:0]);
      end
      consume32;
    end
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    int lat, want_lat;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      want_lat = (op[2] && b == 32'd0) ? 1 : 34;
      issue32(op, a, b, model32(op, a, b));
      wait32(lat);
      e = sbq.pop_front();
      checks++;
      if (lat != want_lat || res !== e[31:0]) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 i, op, a, b, res, lat, e[31:0], want_lat);
      end
      consume32;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [63:0] e;
    logic [31:0] held;
    issue32(3'd0, 32'd1234, 32'd5678, 32'd7006652);
    wait32(lat);
    held = res;
    e = sbq.pop_front();
    checks++;
    if (held !== e[31:0]) begin
      errors++;
      $display("FAIL backpressure first result: got %h want %h", held, e[31:0]);
    end
    op_in = 3'd5; src1_in = 32'd100; src2_in = 32'd7; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rv !== 1'b1 || res !== held || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold[%0d]: valid=%b result=%h ready=%b want 1/%h/0", i, rv, res, ready_out, held);
      end
    end
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    checks++;
    if (rv !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL backpressure no-accept-on-handshake: valid=%b ready=%b want 0/1", rv, ready_out);
    end
    sbq.push_back(64'd14);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    wait32(lat);
    e = sbq.pop_front();
    checks++;
    if (lat != 34 || res !== e[31:0]) begin
      errors++;
      $display("FAIL backpressure second op: got %h lat %0d want %h lat 34", res, lat, e[31:0]);
    end
    consume32;
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    op_in = 3'd0; src1_in = 32'd3; src2_in = 32'd9; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    checks++;
    if (ready_out !== 1'b1 || rv !== 1'b0) begin
      errors++;
      $display("FAIL flush: ready=%b valid=%b want 1/0", ready_out, rv);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush no-result: valid seen %0d cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    op_in = 3'd4; src1_in = 32'd1000; src2_in = 32'd3; valid_in = 1'b1;
    op64 = 3'd0; s1_64 = 64'd77; s2_64 = 64'd3; v64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0; v64 = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (rv !== 1'b0 || res !== 32'd0 || ready_out !== 1'b1 ||
        rv64 !== 1'b0 || res64 !== 64'd0 || rdy64 !== 1'b1) begin
      errors++;
      $display("FAIL reset mid-busy: v32=%b r32=%h rdy32=%b v64=%b r64=%h rdy64=%b want reset values",
               rv, res, ready_out, rv64, res64, rdy64);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rv !== 1'b0 || rv64 !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-busy leftover: valid32=%b valid64=%b want 0/0", rv, rv64);
    end
  endtask

  task automatic test_xlen64;
    logic [2:0]  ops[7] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5};
    logic [63:0] as[7]  = '{64'd7, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF9,
                            64'd100, 64'd100, 64'd5};
    logic [63:0] bs[7]  = '{64'hFFFFFFFFFFFFFFFD, 64'h8000000000000000, 64'd2, 64'd2, 64'd7, 64'd7, 64'd0};
    logic [63:0] ex[7]  = '{64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000, 64'hFFFFFFFFFFFFFFFD,
                            64'hFFFFFFFFFFFFFFFF, 64'd14, 64'd2, 64'hFFFFFFFFFFFFFFFF};
    int lats[7] = '{66, 66, 66, 66, 66, 66, 1};
    int lat;
    logic [63:0] e;
    for (int i = 0; i < 7; i++) begin
      issue64(ops[i], as[i], bs[i], ex[i]);
      wait64(lat);
      e = sbq.pop_front();
      checks++;
      if (lat != lats[i]) begin
        errors++;
        $display("FAIL xlen64[%0d] latency: got %0d want %0d", i, lat, lats[i]);
      end
      checks++;
      if (res64 !== e) begin
        errors++;
        $display("FAIL xlen64[%0d] result op=%0d: got %h want %h", i, ops[i], res64, e);
      end
      consume64;
    end
  endtask

  initial begin
    valid_in = 1'b0; op_in = 3'd0; src1_in = '0; src2_in = '0; flush_in = 1'b0; rr = 1'b0;
    v64 = 1'b0; op64 = 3'd0; s1_64 = '0; s2_64 = '0; fl64 = 1'b0; rr64 = 1'b0;
    test_reset;
    test_normal32;
    test_fast_path;
    test_random;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_xlen64;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
